// File: rtl/softmax_chk_pkg.sv
// softmax_chk_pkg
// Shared constants, state encoding and width helpers for the softmax
// result checker.
package softmax_chk_pkg;

   // 1.0 in unsigned Q8.8
   localparam logic [15:0] Q88_ONE = 16'h0100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } state_t;

   // Index width; kept at least 1 so a single-element vector still has a
   // legal index register.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Accumulator width: N full-scale 16-bit elements cannot overflow it.
   function automatic int sum_w(input int n);
      return 16 + $clog2(n);
   endfunction

endpackage

// File: rtl/softmax_result_checker_if.sv
// softmax_result_checker_if
// Softmax output bus as seen by the checker.
//   valid_in  : single-cycle strobe, prob_flat valid this cycle
//   prob_flat : N unsigned Q8.8 probabilities, element i = [16*i+15:16*i]
// master drives the bus (softmax core / testbench), slave samples it.
interface softmax_result_checker_if #(
   parameter int N = 64
);
   logic              valid_in;
   logic [N*16-1:0]   prob_flat;

   modport master (output valid_in, output prob_flat);
   modport slave  (input  valid_in, input  prob_flat);
endinterface

// File: rtl/softmax_result_checker.sv
// softmax_result_checker
// Latches one N-element Q8.8 probability vector per valid_in strobe, walks
// it one element per clock and reports sum, argmax, max value, a range
// check and a pass/fail verdict.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   in_if         : slave side of the softmax output bus
//   busy          : vector in ACCUM or REPORT
//   done          : one-cycle pulse, result outputs updated this cycle
//   pass          : |sum - 1.0| <= TOL and no element above 1.0
//   sum_out       : sum of last vector
//   argmax_idx    : lowest index of the largest element
//   max_prob      : largest element
//   range_err     : some element exceeded 1.0
//   result_count  : vectors completed since reset (wraps)
//   fail_count    : vectors with pass=0 since reset (wraps)
//   overrun       : sticky, valid_in arrived while busy
module softmax_result_checker
   import softmax_chk_pkg::*;
#(
   parameter  int N   = 64,
   parameter  int TOL = 8,
   parameter  int CW  = 16,
   localparam int SW  = sum_w(N),
   localparam int IW  = idx_w(N)
) (
   input  logic                   clk,
   input  logic                   rst,
   softmax_result_checker_if.slave in_if,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [SW-1:0]          sum_out,
   output logic [IW-1:0]          argmax_idx,
   output logic [15:0]            max_prob,
   output logic                   range_err,
   output logic [CW-1:0]          result_count,
   output logic [CW-1:0]          fail_count,
   output logic                   overrun
);

   localparam logic [IW-1:0] LAST    = IW'(N - 1);
   localparam logic [SW-1:0] ONE_W   = SW'(Q88_ONE);
   localparam logic [SW-1:0] TOL_W   = SW'(TOL);

   state_t               state, state_nx;
   logic [N-1:0][15:0]   vec;
   logic [IW-1:0]        idx;
   logic [SW-1:0]        acc;
   logic [15:0]          mx;
   logic [IW-1:0]        arg;
   logic                 rflag;

   logic [15:0]          elem;
   logic [SW-1:0]        dev;
   logic                 verdict;

   assign elem = vec[idx];
   assign busy = (state != IDLE);

   // Absolute deviation from 1.0 at full accumulator width
   assign dev     = (acc >= ONE_W) ? (acc - ONE_W) : (ONE_W - acc);
   assign verdict = (dev <= TOL_W) && !rflag;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_if.valid_in) state_nx = ACCUM;
         ACCUM:   if (idx == LAST)    state_nx = REPORT;
         REPORT:                      state_nx = IDLE;
         default:                     state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec          <= '0;
         idx          <= '0;
         acc          <= '0;
         mx           <= '0;
         arg          <= '0;
         rflag        <= 1'b0;
         done         <= 1'b0;
         pass         <= 1'b0;
         sum_out      <= '0;
         argmax_idx   <= '0;
         max_prob     <= '0;
         range_err    <= 1'b0;
         result_count <= '0;
         fail_count   <= '0;
         overrun      <= 1'b0;
      end else begin
         done <= (state == REPORT);

         // A strobe is only accepted in IDLE; anything else is dropped
         if (in_if.valid_in && busy) overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (in_if.valid_in) begin
                  vec   <= in_if.prob_flat;
                  idx   <= '0;
                  acc   <= '0;
                  mx    <= '0;
                  arg   <= '0;
                  rflag <= 1'b0;
               end
            end
            ACCUM: begin
               acc <= acc + SW'(elem);
               // strict compare keeps the lowest index on ties
               if (elem > mx) begin
                  mx  <= elem;
                  arg <= idx;
               end
               if (elem > Q88_ONE) rflag <= 1'b1;
               idx <= idx + 1'b1;
            end
            REPORT: begin
               sum_out      <= acc;
               argmax_idx   <= arg;
               max_prob     <= mx;
               range_err    <= rflag;
               pass         <= verdict;
               result_count <= result_count + 1'b1;
               if (!verdict) fail_count <= fail_count + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_result_checker.sv
// tb_softmax_result_checker
// Two checker instances: N=4 for the functional cases, N=64 for the
// default-size and mid-vector reset cases. Expected results are pushed to
// a per-instance queue when a vector is driven and popped at done.
module tb_softmax_result_checker;
   import softmax_chk_pkg::*;

   localparam int N1 = 4;
   localparam int N2 = 64;
   localparam int WAIT_MAX = 200;

   typedef struct packed {
      logic [31:0] sum;
      logic [31:0] arg;
      logic [31:0] mx;
      logic        rerr;
      logic        pass;
      logic [31:0] rc;
      logic [31:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst, rst2;
   always #5 clk = ~clk;

   softmax_result_checker_if #(.N(N1)) if1();
   softmax_result_checker_if #(.N(N2)) if2();

   logic              busy1, done1, pass1, rerr1, ovr1;
   logic [17:0]       sum1;
   logic [1:0]        arg1;
   logic [15:0]       max1;
   logic [15:0]       rc1_o, fc1_o;

   logic              busy2, done2, pass2, rerr2, ovr2;
   logic [21:0]       sum2;
   logic [5:0]        arg2;
   logic [15:0]       max2;
   logic [15:0]       rc2_o, fc2_o;

   softmax_result_checker #(.N(N1), .TOL(8), .CW(16)) dut1 (
      .clk(clk), .rst(rst), .in_if(if1),
      .busy(busy1), .done(done1), .pass(pass1), .sum_out(sum1),
      .argmax_idx(arg1), .max_prob(max1), .range_err(rerr1),
      .result_count(rc1_o), .fail_count(fc1_o), .overrun(ovr1)
   );

   softmax_result_checker #(.N(N2), .TOL(8), .CW(16)) dut2 (
      .clk(clk), .rst(rst2), .in_if(if2),
      .busy(busy2), .done(done2), .pass(pass2), .sum_out(sum2),
      .argmax_idx(arg2), .max_prob(max2), .range_err(rerr2),
      .result_count(rc2_o), .fail_count(fc2_o), .overrun(ovr2)
   );

   exp_t        q1[$], q2[$];
   int unsigned rc1 = 0, fc1 = 0, rc2 = 0, fc2 = 0;
   int          n_chk = 0, n_fail = 0;

   // Reference: straight walk over the elements
   function automatic exp_t model(input logic [N2*16-1:0] flat, input int n,
                                  input int unsigned rc, input int unsigned fc);
      exp_t e;
      int unsigned v, dev;
      e = '0;
      for (int i = 0; i < n; i++) begin
         v = 32'(flat[16*i +: 16]);
         e.sum = e.sum + v;
         if (v > e.mx) begin
            e.mx  = v;
            e.arg = i;
         end
         if (v > 32'h100) e.rerr = 1'b1;
      end
      dev    = (e.sum >= 32'h100) ? e.sum - 32'h100 : 32'h100 - e.sum;
      e.pass = (dev <= 8) && !e.rerr;
      e.rc   = rc + 1;
      e.fc   = fc + (e.pass ? 0 : 1);
      return e;
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("sum=%0h arg=%0d max=%0h rerr=%0b pass=%0b rc=%0d fc=%0d",
                       e.sum, e.arg, e.mx, e.rerr, e.pass, e.rc, e.fc);
   endfunction

   function automatic exp_t snap1();
      exp_t g;
      g = '{sum: 32'(sum1), arg: 32'(arg1), mx: 32'(max1), rerr: rerr1,
            pass: pass1, rc: 32'(rc1_o), fc: 32'(fc1_o)};
      return g;
   endfunction

   function automatic exp_t snap2();
      exp_t g;
      g = '{sum: 32'(sum2), arg: 32'(arg2), mx: 32'(max2), rerr: rerr2,
            pass: pass2, rc: 32'(rc2_o), fc: 32'(fc2_o)};
      return g;
   endfunction

   function automatic logic [N1*16-1:0] mk4(input logic [15:0] e0, e1, e2, e3);
      return {e3, e2, e1, e0};
   endfunction

   // Drive one strobe from the current negedge; return at the next negedge
   task automatic poke1(input logic [N1*16-1:0] v);
      if1.valid_in  = 1'b1;
      if1.prob_flat = v;
      @(negedge clk);
      if1.valid_in  = 1'b0;
   endtask

   task automatic send1(input logic [N1*16-1:0] v);
      exp_t e;
      e   = model({{(N2-N1)*16{1'b0}}, v}, N1, rc1, fc1);
      rc1 = e.rc;
      fc1 = e.fc;
      q1.push_back(e);
      poke1(v);
   endtask

   task automatic send2(input logic [N2*16-1:0] v);
      exp_t e;
      e   = model(v, N2, rc2, fc2);
      rc2 = e.rc;
      fc2 = e.fc;
      q2.push_back(e);
      if2.valid_in  = 1'b1;
      if2.prob_flat = v;
      @(negedge clk);
      if2.valid_in  = 1'b0;
   endtask

   // Negedges until done is seen, bounded
   task automatic wait_done1(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done1 && cyc < WAIT_MAX);
   endtask

   task automatic wait_done2(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!done2 && cyc < WAIT_MAX);
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      rst2 = 1'b1;
      if1.valid_in = 1'b0; if1.prob_flat = '0;
      if2.valid_in = 1'b0; if2.prob_flat = '0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (snap1() !== exp_t'('0)) begin
         n_fail++;
         $display("FAIL reset_outputs1: got %s, expected all zero", fmt(snap1()));
      end
      n_chk++;
      if ({busy1, done1, ovr1} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags1: got busy/done/ovr=%b, expected 000", {busy1, done1, ovr1});
      end
      n_chk++;
      if ({busy2, done2, ovr2, snap2()} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs2: got %s busy=%b done=%b, expected all zero",
                  fmt(snap2()), busy2, done2);
      end
      rst  = 1'b0;
      rst2 = 1'b0;
      @(negedge clk);
   endtask

   // Generic single-vector case on the N=4 instance
   task automatic run_vec1(input string name, input logic [N1*16-1:0] v);
      int   cyc;
      exp_t e, g;
      send1(v);
      n_chk++;
      if (busy1 !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_busy: got %b, expected 1", name, busy1);
      end
      wait_done1(cyc);
      // send1 returns one cycle after the sampling edge
      n_chk++;
      if (cyc !== N1 + 1) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d, expected %0d", name, cyc, N1 + 1);
      end
      g = snap1();
      e = q1.pop_front();
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s_result: got %s, expected %s", name, fmt(g), fmt(e));
      end
      @(negedge clk);
   endtask

   task automatic test_uniform();
      run_vec1("uniform", mk4(16'h0040, 16'h0040, 16'h0040, 16'h0040));
   endtask

   task automatic test_argmax();
      run_vec1("argmax", mk4(16'h0010, 16'h00A0, 16'h0030, 16'h0020));
   endtask

   task automatic test_tolerance();
      run_vec1("low_sum",  mk4(16'h0020, 16'h0020, 16'h0020, 16'h0020));
      run_vec1("tol_edge", mk4(16'h0042, 16'h0042, 16'h0042, 16'h0042));
      run_vec1("tol_over", mk4(16'h0043, 16'h0042, 16'h0042, 16'h0042));
   endtask

   task automatic test_range();
      run_vec1("range", mk4(16'h0000, 16'h0101, 16'h0000, 16'h0000));
   endtask

   task automatic test_back_to_back();
      int   cyc;
      exp_t e, g;
      send1(mk4(16'h0050, 16'h0030, 16'h0060, 16'h0020));
      @(negedge clk);
      // strobe sampled two edges after acceptance, while in ACCUM
      poke1(mk4(16'h0100, 16'h0100, 16'h0100, 16'h0100));
      wait_done1(cyc);
      n_chk++;
      if (cyc !== N1 - 1) begin
         n_fail++;
         $display("FAIL overrun_latency: got %0d, expected %0d", cyc, N1 - 1);
      end
      n_chk++;
      if (ovr1 !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_flag: got %b, expected 1", ovr1);
      end
      g = snap1();
      e = q1.pop_front();
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL overrun_result: got %s, expected %s", fmt(g), fmt(e));
      end
      // still in the done cycle: this strobe must be accepted
      send1(mk4(16'h0000, 16'h0000, 16'h0080, 16'h0080));
      wait_done1(cyc);
      n_chk++;
      if (cyc + 1 !== N1 + 2) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d, expected %0d", cyc + 1, N1 + 2);
      end
      g = snap1();
      e = q1.pop_front();
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL b2b_result: got %s, expected %s", fmt(g), fmt(e));
      end
      @(negedge clk);
      n_chk++;
      if ({done1, busy1, ovr1} !== 3'b001) begin
         n_fail++;
         $display("FAIL done_pulse: got done/busy/ovr=%b, expected 001", {done1, busy1, ovr1});
      end
   endtask

   task automatic test_reset_mid();
      int                 cyc, seen;
      exp_t               e, g;
      logic [N2*16-1:0]   ramp, flat4;
      for (int i = 0; i < N2; i++) begin
         ramp[16*i +: 16]  = 16'(i);
         flat4[16*i +: 16] = 16'h0004;
      end
      send2(ramp);
      wait_done2(cyc);
      n_chk++;
      if (cyc !== N2 + 1) begin
         n_fail++;
         $display("FAIL n64_latency: got %0d, expected %0d", cyc, N2 + 1);
      end
      g = snap2();
      e = q2.pop_front();
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL n64_ramp: got %s, expected %s", fmt(g), fmt(e));
      end
      @(negedge clk);
      send2(flat4);
      repeat (9) @(negedge clk);
      #1 rst2 = 1'b1;
      #1;
      n_chk++;
      if ({busy2, done2, ovr2, snap2()} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset: got %s busy=%b done=%b, expected all zero",
                  fmt(snap2()), busy2, done2);
      end
      q2.delete();
      rc2 = 0;
      fc2 = 0;
      @(negedge clk);
      rst2 = 1'b0;
      seen = 0;
      repeat (N2 + 10) begin
         @(negedge clk);
         if (done2 || busy2) seen++;
      end
      n_chk++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL aborted_done: got %0d active cycles, expected 0", seen);
      end
      send2(flat4);
      wait_done2(cyc);
      n_chk++;
      if (cyc !== N2 + 1) begin
         n_fail++;
         $display("FAIL n64_fresh_latency: got %0d, expected %0d", cyc, N2 + 1);
      end
      g = snap2();
      e = q2.pop_front();
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL n64_fresh: got %s, expected %s", fmt(g), fmt(e));
      end
   endtask

   initial begin
      test_reset();
      test_uniform();
      test_argmax();
      test_tolerance();
      test_range();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
